// File: rtl/seg_mem_reader_if.sv
// Request / memory-bus / response signal bundle for seg_mem_reader.
// The slave modport is the reader itself; the master modport is the side
// that issues requests, returns memory bytes and consumes responses.
interface seg_mem_reader_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [15:0] REQ_SEG;
  logic [15:0] REQ_OFF;
  logic        REQ_WORD;
  logic [19:0] MEM_ADDR;
  logic        MEM_RD;
  logic        MEM_ACK;
  logic [7:0]  MEM_DATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [15:0] RSP_DATA;
  logic        RSP_ERR;

  modport slave (
    input  REQ_VALID, REQ_SEG, REQ_OFF, REQ_WORD, MEM_ACK, MEM_DATA, RSP_READY,
    output REQ_READY, MEM_ADDR, MEM_RD, RSP_VALID, RSP_DATA, RSP_ERR
  );

  modport master (
    output REQ_VALID, REQ_SEG, REQ_OFF, REQ_WORD, MEM_ACK, MEM_DATA, RSP_READY,
    input  REQ_READY, MEM_ADDR, MEM_RD, RSP_VALID, RSP_DATA, RSP_ERR
  );
endinterface

// File: rtl/seg_mem_reader.sv
// Segmented memory reader: turns a segment:offset request into one or two
// byte reads on an 8-bit bus and returns a byte or little-endian word.
// Optional feature macro: RD_TIMEOUT_EN (aborts a read that sees no MEM_ACK
// for TIMEOUT_CYCLES strobe cycles, answering 16'hFFFF with RSP_ERR=1).
module seg_mem_reader #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic            CLK,
  input logic            RST,
  seg_mem_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, RESP} state_t;

  state_t      state;
  logic [15:0] seg_q;
  logic [15:0] off_q;
  logic        word_q;
  logic [19:0] mem_addr;
  logic        mem_rd;
  logic        rsp_valid;
  logic [15:0] rsp_data;

  // Reject an out-of-range timeout at elaboration time.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("seg_mem_reader: TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef RD_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;
  logic       rsp_err;
`endif

  // Physical address is SEG*16 + OFF, wrapping at 1 MiB.
  function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

  // Read sequencer: accept, fetch low byte, optionally fetch high byte
  // (offset wraps inside the segment), then hold the response until taken.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      seg_q     <= 16'h0000;
      off_q     <= 16'h0000;
      word_q    <= 1'b0;
      mem_addr  <= 20'h00000;
      mem_rd    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
`ifdef RD_TIMEOUT_EN
      tmo_cnt   <= 8'h00;
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.REQ_VALID) begin
            seg_q    <= bus.REQ_SEG;
            off_q    <= bus.REQ_OFF;
            word_q   <= bus.REQ_WORD;
            mem_addr <= phys_addr(bus.REQ_SEG, bus.REQ_OFF);
            mem_rd   <= 1'b1;
            state    <= RD_LO;
`ifdef RD_TIMEOUT_EN
            tmo_cnt  <= 8'h00;
`endif
          end
        end
        RD_LO: begin
          if (bus.MEM_ACK) begin
`ifdef RD_TIMEOUT_EN
            tmo_cnt <= 8'h00;
`endif
            if (word_q) begin
              rsp_data[7:0] <= bus.MEM_DATA;
              mem_addr      <= phys_addr(seg_q, off_q + 16'd1);
              state         <= RD_HI;
            end else begin
              rsp_data  <= {8'h00, bus.MEM_DATA};
              mem_rd    <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
`ifdef RD_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            rsp_data  <= 16'hFFFF;
            rsp_err   <= 1'b1;
            mem_rd    <= 1'b0;
            rsp_valid <= 1'b1;
            tmo_cnt   <= 8'h00;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        RD_HI: begin
          if (bus.MEM_ACK) begin
            rsp_data[15:8] <= bus.MEM_DATA;
            mem_rd         <= 1'b0;
            rsp_valid      <= 1'b1;
            state          <= RESP;
`ifdef RD_TIMEOUT_EN
            tmo_cnt        <= 8'h00;
`endif
          end
`ifdef RD_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            rsp_data  <= 16'hFFFF;
            rsp_err   <= 1'b1;
            mem_rd    <= 1'b0;
            rsp_valid <= 1'b1;
            tmo_cnt   <= 8'h00;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          if (bus.RSP_READY) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
`ifdef RD_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.REQ_READY = (state == IDLE);
  assign bus.MEM_ADDR  = mem_addr;
  assign bus.MEM_RD    = mem_rd;
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_DATA  = rsp_data;
`ifdef RD_TIMEOUT_EN
  assign bus.RSP_ERR   = rsp_err;
`else
  assign bus.RSP_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_seg_mem_reader.sv
// Testbench for seg_mem_reader: directed reads with a scoreboard of expected
// bus addresses and responses, checked by an independent monitor.
// Honours RD_TIMEOUT_EN the same way the design does.
module tb_seg_mem_reader;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  logic CLK;
  logic RST;
  seg_mem_reader_if bus();

  seg_mem_reader #(.TIMEOUT_CYCLES(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  rsp_t       rsp_q[$];
  logic [19:0] addr_q[$];
  logic [7:0]  mem_q[$];
  int ack_delay = 0;
  int rsp_hold  = 0;
  int wait_cnt  = 0;
  int hold_cnt  = 0;

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Overall run-time guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Memory and requester model: returns queued bytes after ack_delay idle
  // strobe cycles, and accepts a response after rsp_hold waiting cycles.
  always @(posedge CLK) begin
    #1;
    if (RST && bus.MEM_RD && mem_q.size() > 0) begin
      if (wait_cnt == ack_delay) begin
        bus.MEM_ACK  = 1'b1;
        bus.MEM_DATA = mem_q.pop_front();
        wait_cnt     = 0;
      end else begin
        bus.MEM_ACK  = 1'b0;
        bus.MEM_DATA = 8'hEE;
        wait_cnt++;
      end
    end else begin
      bus.MEM_ACK  = 1'b0;
      bus.MEM_DATA = 8'hEE;
      wait_cnt     = 0;
    end
    if (RST && bus.RSP_VALID) begin
      bus.RSP_READY = (hold_cnt == rsp_hold);
      hold_cnt++;
    end else begin
      bus.RSP_READY = 1'b0;
      hold_cnt      = 0;
    end
  end

  // Monitor: compare every acknowledged bus address and every accepted
  // response against the scoreboard.
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.MEM_RD && bus.MEM_ACK) begin
        if (addr_q.size() == 0) begin
          checkOutput("unexpected_mem_ack_addr", 32'(bus.MEM_ADDR), 32'hFFFF_FFFF);
        end else begin
          checkOutput("mem_addr", 32'(bus.MEM_ADDR), 32'(addr_q.pop_front()));
        end
      end
      if (bus.RSP_VALID && bus.RSP_READY) begin
        if (rsp_q.size() == 0) begin
          checkOutput("unexpected_response", 32'(bus.RSP_DATA), 32'hFFFF_FFFF);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          checkOutput("rsp_data", 32'(bus.RSP_DATA), 32'(e.data));
          checkOutput("rsp_err", 32'(bus.RSP_ERR), 32'(e.err));
        end
      end
    end
  end

  // Issue one request and check its timing; data goes through the scoreboard.
  task automatic applyStimulus(
    input string name, input logic [15:0] seg, input logic [15:0] off, input logic word,
    input logic [19:0] a_lo, input logic [19:0] a_hi, input logic [7:0] b_lo, input logic [7:0] b_hi,
    input int nbytes, input logic [15:0] exp_data, input logic exp_err,
    input int d, input int hold, input int exp_lat, input int exp_strobes);
    int lat, strobes, vcycles;
    logic busy_ok, stable;
    logic [15:0] held;
    ack_delay = d;
    rsp_hold  = hold;
    if (nbytes >= 1) begin addr_q.push_back(a_lo); mem_q.push_back(b_lo); end
    if (nbytes >= 2) begin addr_q.push_back(a_hi); mem_q.push_back(b_hi); end
    rsp_q.push_back('{exp_data, exp_err});
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b1;
    bus.REQ_SEG   = seg;
    bus.REQ_OFF   = off;
    bus.REQ_WORD  = word;
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_SEG   = 16'hDEAD;
    bus.REQ_OFF   = 16'hBEEF;
    lat = 0; strobes = 0; busy_ok = 1'b1;
    do begin
      @(negedge CLK);
      lat++;
      if (bus.MEM_RD) strobes++;
      if (bus.REQ_READY) busy_ok = 1'b0;
    end while (!bus.RSP_VALID && lat < 100);
    held = bus.RSP_DATA; stable = 1'b1; vcycles = 1;
    while (vcycles < 100) begin
      @(negedge CLK);
      if (!bus.RSP_VALID) break;
      vcycles++;
      if (bus.RSP_DATA !== held) stable = 1'b0;
      if (bus.REQ_READY) busy_ok = 1'b0;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, "_strobes"}, 32'(strobes), 32'(exp_strobes));
    checkOutput({name, "_valid_cycles"}, 32'(vcycles), 32'(hold + 1));
    checkOutput({name, "_data_stable"}, 32'(stable), 32'd1);
    checkOutput({name, "_req_ready_low_while_busy"}, 32'(busy_ok), 32'd1);
    checkOutput({name, "_req_ready_after"}, 32'(bus.REQ_READY), 32'd1);
  endtask

  initial begin
    int n;
    logic ok;
    bus.REQ_VALID = 1'b0;
    bus.REQ_SEG   = 16'h0000;
    bus.REQ_OFF   = 16'h0000;
    bus.REQ_WORD  = 1'b0;
    bus.MEM_ACK   = 1'b0;
    bus.MEM_DATA  = 8'h00;
    bus.RSP_READY = 1'b0;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_mem_rd", 32'(bus.MEM_RD), 32'd0);
    checkOutput("reset_mem_addr", 32'(bus.MEM_ADDR), 32'd0);
    checkOutput("reset_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    checkOutput("reset_rsp_data", 32'(bus.RSP_DATA), 32'd0);
    checkOutput("reset_rsp_err", 32'(bus.RSP_ERR), 32'd0);
    checkOutput("reset_req_ready", 32'(bus.REQ_READY), 32'd1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] directed reads");
    applyStimulus("byte_1234_0010", 16'h1234, 16'h0010, 1'b0, 20'h12350, 20'h0, 8'hA5, 8'h00,
                  1, 16'h00A5, 1'b0, 0, 0, 2, 1);
    applyStimulus("word_2000_ffff", 16'h2000, 16'hFFFF, 1'b1, 20'h2FFFF, 20'h20000, 8'h34, 8'h12,
                  2, 16'h1234, 1'b0, 0, 0, 3, 2);
    applyStimulus("byte_ffff_0010", 16'hFFFF, 16'h0010, 1'b0, 20'h00000, 20'h0, 8'h5C, 8'h00,
                  1, 16'h005C, 1'b0, 0, 0, 2, 1);
    applyStimulus("word_ffff_000f", 16'hFFFF, 16'h000F, 1'b1, 20'hFFFFF, 20'h00000, 8'h78, 8'h9A,
                  2, 16'h9A78, 1'b0, 0, 0, 3, 2);
    applyStimulus("byte_slow", 16'h0100, 16'h0020, 1'b0, 20'h01020, 20'h0, 8'hC3, 8'h00,
                  1, 16'h00C3, 1'b0, 3, 4, 5, 4);
    applyStimulus("word_slow", 16'h0ABC, 16'h1234, 1'b1, 20'h0BDF4, 20'h0BDF5, 8'h11, 8'h22,
                  2, 16'h2211, 1'b0, 1, 2, 5, 4);

    $display("[TB] reset during high-byte read");
    ack_delay = 0; rsp_hold = 0;
    addr_q.push_back(20'h40010);
    mem_q.push_back(8'h55);
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b1; bus.REQ_SEG = 16'h4000; bus.REQ_OFF = 16'h0010; bus.REQ_WORD = 1'b1;
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b0;
    n = 0; ok = 1'b0;
    while (n < 20 && !ok) begin
      @(negedge CLK);
      n++;
      ok = bus.MEM_RD && (bus.MEM_ADDR == 20'h40011);
    end
    checkOutput("reached_rd_hi", 32'(ok), 32'd1);
    #1 RST = 1'b0;
    #1;
    checkOutput("async_reset_mem_rd", 32'(bus.MEM_RD), 32'd0);
    checkOutput("async_reset_req_ready", 32'(bus.REQ_READY), 32'd1);
    checkOutput("async_reset_mem_addr", 32'(bus.MEM_ADDR), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      if (bus.RSP_VALID || !bus.REQ_READY || bus.MEM_RD) ok = 1'b0;
    end
    checkOutput("no_response_after_reset", 32'(ok), 32'd1);
    applyStimulus("word_after_reset", 16'h3000, 16'h0001, 1'b1, 20'h30001, 20'h30002, 8'hEF, 8'hBE,
                  2, 16'hBEEF, 1'b0, 0, 0, 3, 2);

`ifdef RD_TIMEOUT_EN
    $display("[TB] read with no acknowledge, timeout enabled");
    applyStimulus("timeout", 16'h5000, 16'h0000, 1'b1, 20'h50000, 20'h50001, 8'h00, 8'h00,
                  0, 16'hFFFF, 1'b1, 0, 0, 5, 4);
    checkOutput("rsp_err_cleared_in_idle", 32'(bus.RSP_ERR), 32'd0);
`else
    $display("[TB] read with no acknowledge, timeout disabled");
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b1; bus.REQ_SEG = 16'h5000; bus.REQ_OFF = 16'h0000; bus.REQ_WORD = 1'b1;
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (!bus.MEM_RD || bus.RSP_VALID || bus.RSP_ERR || bus.MEM_ADDR != 20'h50000) ok = 1'b0;
    end
    checkOutput("no_ack_waits_forever", 32'(ok), 32'd1);
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
`endif

    repeat (3) @(negedge CLK);
    checkOutput("scoreboard_rsp_left", 32'(rsp_q.size()), 32'd0);
    checkOutput("scoreboard_addr_left", 32'(addr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
